// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one fixed-latency memory port between
// instruction fetch and data load/store, with a one-cycle bubble after each ack.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_ack,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [3:0]       dm_be,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic             dm_ack,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             pc_stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic       last_grant;
  logic       owner;
  logic [3:0] lat_cnt;
  logic       grant_any;
  logic       grant_sel;

  // Byte offsets are dropped; the memory only sees word addresses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_any = if_req | dm_req;
    if (if_req && dm_req) begin
      grant_sel = ~last_grant;
    end else if (dm_req) begin
      grant_sel = DATA;
    end else begin
      grant_sel = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= FETCH;
      owner      <= FETCH;
      lat_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner   <= grant_sel;
            mem_req <= 1'b1;
            lat_cnt <= '0;
            state   <= BUSY;
            if (grant_sel == DATA) begin
              mem_addr  <= {dm_addr[WIDTH-1:2], 2'b00};
              mem_we    <= dm_we;
              mem_be    <= dm_we ? dm_be : 4'b1111;
              mem_wdata <= dm_wdata;
            end else begin
              mem_addr  <= {if_addr[WIDTH-1:2], 2'b00};
              mem_we    <= 1'b0;
              mem_be    <= 4'b1111;
            end
          end
        end
        BUSY: begin
          // Read data is only valid on the final cycle of the fixed latency.
          if (lat_cnt == LAT_LAST) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            last_grant <= owner;
            state      <= RESP;
            if (owner == DATA) begin
              dm_ack <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RESP: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pc_stall = if_req & ~if_ack;

  // Simulation-only sanity checks on configuration and ack exclusivity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (MEM_LAT >= 1 && MEM_LAT <= 15)
        else $error("mem_port_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);
      assert (!(if_ack && dm_ack))
        else $error("mem_port_arbiter: both acks asserted");
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter, checked against a
// transaction-level model that predicts grants, ack timing and memory contents.
module tb_mem_port_arbiter;

  localparam int WIDTH   = 32;
  localparam int MEM_LAT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_ack;
  logic [WIDTH-1:0] if_rdata;
  logic             dm_req;
  logic             dm_we;
  logic [3:0]       dm_be;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic             dm_ack;
  logic [WIDTH-1:0] dm_rdata;
  logic             mem_req;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             pc_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(WIDTH), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pc_stall(pc_stall)
  );

  // Memory macro: data is valid only on the MEM_LAT-th request cycle, junk otherwise.
  logic [31:0] init_vals [16];
  logic [31:0] mem_array [16];
  bit          mem_init = 1'b1;
  int          mem_cyc = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem_array[i] <= init_vals[i];
      mem_cyc <= 0;
    end else if (mem_req) begin
      if (mem_cyc == MEM_LAT - 1 && mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem_array[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_cyc <= mem_cyc + 1;
    end else begin
      mem_cyc <= 0;
    end
  end

  assign mem_rdata = (mem_req && mem_cyc == MEM_LAT - 1) ? mem_array[mem_addr[5:2]]
                                                         : (32'hBAD0_0000 | 32'(mem_cyc));

  // Reference model state, indexed by clock edge number e.
  int          checks = 0;
  int          errors = 0;
  int          e = 0;
  logic [31:0] ref_mem [16];
  bit          m_busy, m_own_dm, m_we, m_last_dm;
  int          m_g, m_free;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] exp_if_rdata, exp_dm_rdata;
  bit          exp_if_ack, exp_dm_ack;
  bit          auto_drop = 1'b1;
  bit          f_dropped, d_dropped;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int idx;
    exp_if_ack = 1'b0;
    exp_dm_ack = 1'b0;
    if (m_busy && e == m_g + MEM_LAT) begin
      idx = int'(m_addr[5:2]);
      if (m_own_dm) begin
        exp_dm_ack = 1'b1;
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) ref_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          exp_dm_rdata = ref_mem[idx];
        end
      end else begin
        exp_if_ack   = 1'b1;
        exp_if_rdata = ref_mem[idx];
      end
    end
    if (e >= m_free && (if_req || dm_req)) begin
      m_own_dm  = (if_req && dm_req) ? !m_last_dm : dm_req;
      m_last_dm = m_own_dm;
      m_busy    = 1'b1;
      m_g       = e;
      m_free    = e + MEM_LAT + 2;
      if (m_own_dm) begin
        m_addr = dm_addr; m_we = dm_we; m_be = dm_be; m_wdata = dm_wdata;
      end else begin
        m_addr = if_addr; m_we = 1'b0; m_be = 4'hF; m_wdata = 32'h0;
      end
    end
  endtask

  task automatic check_cycle();
    bit in_acc;
    in_acc = m_busy && e >= m_g && e < m_g + MEM_LAT;
    checkOutput("mem_req", mem_req, in_acc);
    checkOutput("mem_we", mem_we, in_acc && m_we);
    if (in_acc) begin
      checkOutput("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
      checkOutput("mem_be", mem_be, (m_own_dm && m_we) ? m_be : 4'hF);
      if (m_we) checkOutput("mem_wdata", mem_wdata, m_wdata);
    end
    checkOutput("if_ack", if_ack, exp_if_ack);
    checkOutput("dm_ack", dm_ack, exp_dm_ack);
    checkOutput("if_rdata", if_rdata, exp_if_rdata);
    checkOutput("dm_rdata", dm_rdata, exp_dm_rdata);
    checkOutput("pc_stall", pc_stall, if_req & ~exp_if_ack);
  endtask

  task automatic cycle();
    @(posedge clk);
    e++;
    #1;
    model_edge();
    check_cycle();
    if (auto_drop) begin
      if (exp_if_ack) if_req = 1'b0;
      if (exp_dm_ack) dm_req = 1'b0;
    end
  endtask

  task automatic applyReset(input int n);
    if_req = 1'b0;
    dm_req = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e++;
      #1;
      checkOutput("rst_mem_req", mem_req, 1'b0);
      checkOutput("rst_mem_we", mem_we, 1'b0);
      checkOutput("rst_mem_be", mem_be, 4'h0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
      checkOutput("rst_if_ack", if_ack, 1'b0);
      checkOutput("rst_dm_ack", dm_ack, 1'b0);
      checkOutput("rst_if_rdata", if_rdata, 32'h0);
      checkOutput("rst_dm_rdata", dm_rdata, 32'h0);
    end
    m_busy = 1'b0; m_last_dm = 1'b0;
    exp_if_rdata = 32'h0; exp_dm_rdata = 32'h0;
    exp_if_ack = 1'b0; exp_dm_ack = 1'b0;
    f_dropped = 1'b0; d_dropped = 1'b0;
    rst      = 1'b0;
    mem_init = 1'b0;
    m_free   = e + 1;
  endtask

  task automatic new_dm_fields();
    dm_we    = 1'($urandom_range(0, 1));
    dm_be    = 4'($urandom);
    dm_addr  = $urandom;
    dm_wdata = $urandom;
  endtask

  // Random requester behaviour: hold until ack, sometimes chain, rarely abandon mid-access.
  task automatic applyStimulus();
    bool_fetch: begin
      if (exp_if_ack) f_dropped = 1'b0;
      if (if_req) begin
        if (exp_if_ack) begin
          if ($urandom_range(0, 2) == 0) if_req = 1'b0;
          else if_addr = $urandom;
        end else if (m_busy && !m_own_dm && e < m_g + MEM_LAT && $urandom_range(0, 15) == 0) begin
          if_req = 1'b0; f_dropped = 1'b1;
        end
      end else if (!f_dropped && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
    end
    bool_data: begin
      if (exp_dm_ack) d_dropped = 1'b0;
      if (dm_req) begin
        if (exp_dm_ack) begin
          if ($urandom_range(0, 2) == 0) dm_req = 1'b0;
          else new_dm_fields();
        end else if (m_busy && m_own_dm && e < m_g + MEM_LAT && $urandom_range(0, 15) == 0) begin
          dm_req = 1'b0; d_dropped = 1'b1;
        end
      end else if (!d_dropped && $urandom_range(0, 3) == 0) begin
        dm_req = 1'b1; new_dm_fields();
      end
    end
  endtask

  initial begin
    int first_if, first_dm, n_acks, ack_at;
    logic [3:0]  order;
    logic [31:0] prior;

    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 16; i++) init_vals[i] = $urandom;
    init_vals[0] = 32'h0;
    init_vals[1] = 32'h0000_0013;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_vals[i];
    applyReset(2);

    $display("[TB] single fetch");
    if_req = 1'b1; if_addr = 32'h0000_0006;
    #1;
    checkOutput("t1_stall_c0", pc_stall, 1'b1);
    cycle();
    checkOutput("t1_addr", mem_addr, 32'h0000_0004);
    checkOutput("t1_req_c1", mem_req, 1'b1);
    repeat (MEM_LAT) cycle();
    checkOutput("t1_ack", if_ack, 1'b1);
    checkOutput("t1_rdata", if_rdata, 32'h0000_0013);
    checkOutput("t1_stall_ack", pc_stall, 1'b0);
    cycle();

    $display("[TB] tie after reset");
    applyReset(1);
    if_req = 1'b1; if_addr = $urandom;
    dm_req = 1'b1; new_dm_fields(); dm_we = 1'b0;
    first_if = 0; first_dm = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (if_ack && first_if == 0) first_if = k;
      if (dm_ack && first_dm == 0) first_dm = k;
    end
    checkOutput("t2_dm_ack_cycle", 32'(first_dm), 32'(MEM_LAT + 1));
    checkOutput("t2_if_ack_cycle", 32'(first_if), 32'(2 * MEM_LAT + 3));

    $display("[TB] round robin");
    applyReset(1);
    auto_drop = 1'b0;
    if_req = 1'b1; if_addr = $urandom;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = $urandom;
    order = 4'h0; n_acks = 0;
    repeat (4 * (MEM_LAT + 2)) begin
      cycle();
      if (if_ack || dm_ack) begin
        order = {order[2:0], dm_ack};
        n_acks++;
      end
    end
    checkOutput("t3_order", order, 4'b1010);
    checkOutput("t3_acks", 32'(n_acks), 32'd4);
    if_req = 1'b0; dm_req = 1'b0; auto_drop = 1'b1;
    repeat (MEM_LAT + 2) cycle();

    $display("[TB] store then load");
    prior = exp_dm_rdata;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011;
    dm_addr = 32'h0000_0100; dm_wdata = 32'hAABB_CCDD;
    cycle();
    checkOutput("t4_store_we", mem_we, 1'b1);
    checkOutput("t4_store_be", mem_be, 4'b0011);
    repeat (MEM_LAT) cycle();
    checkOutput("t4_store_ack", dm_ack, 1'b1);
    checkOutput("t4_rdata_kept", dm_rdata, prior);
    cycle();
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'b0000;
    cycle();
    checkOutput("t4_load_we", mem_we, 1'b0);
    checkOutput("t4_load_be", mem_be, 4'b1111);
    repeat (MEM_LAT) cycle();
    checkOutput("t4_load_data", dm_rdata, 32'h0000_CCDD);
    cycle();

    $display("[TB] reset mid-access");
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = $urandom;
    cycle();
    cycle();
    applyReset(1);
    n_acks = 0;
    repeat (4) begin
      cycle();
      if (dm_ack) n_acks++;
    end
    checkOutput("t5_no_dm_ack", 32'(n_acks), 32'd0);
    if_req = 1'b1; if_addr = $urandom;
    first_if = 0;
    for (int k = 1; k <= MEM_LAT + 3; k++) begin
      cycle();
      if (if_ack && first_if == 0) first_if = k;
    end
    checkOutput("t5_fetch_after_rst", 32'(first_if), 32'(MEM_LAT + 1));

    $display("[TB] fetch request dropped mid-access");
    if_req = 1'b1; if_addr = $urandom;
    cycle();
    if_req = 1'b0;
    n_acks = 0; ack_at = 0;
    for (int k = 2; k <= MEM_LAT + 5; k++) begin
      cycle();
      if (if_ack) begin n_acks++; ack_at = k; end
    end
    checkOutput("t6_ack_count", 32'(n_acks), 32'd1);
    checkOutput("t6_ack_cycle", 32'(ack_at), 32'(MEM_LAT + 1));

    $display("[TB] randomized traffic");
    auto_drop = 1'b0;
    repeat (1500) begin
      cycle();
      applyStimulus();
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (MEM_LAT + 3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the RV32I core. Requesters use a req/ack handshake. The block sequences a fixed-latency memory access and returns read data. It also generates the PC stall consumed by the program counter logic. It sits between prog_ctr/inst_addr on the fetch side, the DM_addr/DM_data path on the data side, and the memory macro.

Parameters:
WIDTH, 32, data and address width
MEM_LAT, 2, memory read latency in cycles from mem_req assertion to valid mem_rdata; legal range 1..15

Ports:
clk  input  1  clock
rst  input  1  reset
if_req  input  1  fetch request; held until if_ack
if_addr  input  WIDTH  fetch byte address
if_ack  output  1  one-cycle pulse; fetch complete, if_rdata valid
if_rdata  output  WIDTH  fetched instruction word
dm_req  input  1  data request; held until dm_ack
dm_we  input  1  1 = store, 0 = load
dm_be  input  4  store byte enables
dm_addr  input  WIDTH  data byte address
dm_wdata  input  WIDTH  store data
dm_ack  output  1  one-cycle pulse; data access complete
dm_rdata  output  WIDTH  load data
mem_req  output  1  memory access active
mem_we  output  1  memory write enable
mem_be  output  4  memory byte enables
mem_addr  output  WIDTH  word-aligned memory address
mem_wdata  output  WIDTH  memory write data
mem_rdata  input  WIDTH  memory read data
pc_stall  output  1  stall the program counter

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE; last_grant = FETCH.
  - mem_req, mem_we, if_ack, dm_ack = 0; mem_be = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If only one request is asserted, grant it.
  - If both are asserted, grant the requester that was not last_grant (round-robin). After reset, DATA wins the first tie.
  - On grant, register owner, mem_addr = {addr[WIDTH-1:2], 2'b00}, mem_we, mem_be, mem_wdata. Set mem_req = 1 and clear the latency counter. Go to BUSY.
  - Fetch grants drive mem_we = 0 and mem_be = 4'b1111.
  - Data loads drive mem_be = 4'b1111. Data stores drive mem_be = dm_be.
- BUSY:
  - mem_req is held at 1 with stable registered outputs for exactly MEM_LAT cycles.
  - On the MEM_LAT-th cycle, capture mem_rdata into the owner's rdata register. Stores do not update dm_rdata.
  - On the same edge, drop mem_req and mem_we, assert the owner's ack, update last_grant = owner, and go to RESP.
- RESP:
  - The ack is high for exactly one cycle, then cleared. Go to IDLE.
  - Requests are not sampled in RESP. This gives one bubble cycle between back-to-back accesses.
- Latency:
  - Request sampled at edge 0 gives mem_req high during cycles 1..MEM_LAT.
  - Ack is high in cycle MEM_LAT+1.
  - Total MEM_LAT+2 cycles per access including the bubble.
- Handshake rules:
  - A requester holds req and its request fields stable until it sees ack.
  - A requester still asserting req in the cycle after ack issues a new request.
  - Request inputs are ignored outside IDLE. Dropping req mid-access does not abort the access; the ack still pulses.
- pc_stall = if_req & ~if_ack (combinational). The PC advances only in the ack cycle.
- rdata registers hold their value until the next read by the same requester.
- Reset mid-access (BUSY or RESP): the access is abandoned. No ack is issued, and all outputs take reset values on that edge. A memory write may have been partially performed; this is accepted.
- Counter width is 4 bits. MEM_LAT outside 1..15 is a configuration error, flagged in simulation only.

Test Plan:
1. MEM_LAT=2, single fetch if_addr=0x0000_0006, mem_rdata=0x0000_0013 → mem_addr=0x0000_0004, mem_req high in cycles 1–2, if_ack=1 in cycle 3, if_rdata=0x13, pc_stall=1 in cycles 0–2 and 0 in cycle 3.
2. Simultaneous if_req and dm_req right after reset → data granted first; fetch granted in the cycle after dm_ack; if_ack in cycle 7.
3. Both requests held continuously for 4 accesses → grants alternate DATA, FETCH, DATA, FETCH, with one RESP bubble between each.
4. Store dm_addr=0x100, dm_be=4'b0011, dm_wdata=0xAABBCCDD, then load 0x100 with mem_rdata=0x0000CCDD → mem_we=1 and mem_be=0011 during the store only; dm_rdata unchanged by the store and 0x0000CCDD after the load.
5. rst asserted in the second BUSY cycle of a load → no dm_ack ever; next cycle all outputs at reset values; a new fetch then completes normally.
6. if_req dropped in cycle 1 of BUSY → access completes; if_ack pulses in cycle MEM_LAT+1; no second access starts.
